// File: rtl/recovery_pkg.sv
// rtl/recovery_pkg.sv - shared types for the recovery routine datapath
// Purpose: regfile port bundles and the rf-restore sequencer state encoding.
// Ports: none (package).
package recovery_pkg;

  localparam int DataWidth          = 32;
  localparam int RegfileAddr        = 5;
  localparam int RfRestoreStateBits = 2;

  typedef logic [RegfileAddr-1:0] regfile_addr_t;
  typedef logic [DataWidth-1:0]   regfile_data_t;

  typedef struct packed {
    regfile_addr_t addr_a;
    regfile_addr_t addr_b;
  } regfile_raddr_t;

  typedef struct packed {
    regfile_data_t data_a;
    regfile_data_t data_b;
  } regfile_rdata_t;

  typedef struct packed {
    logic          we_a;
    regfile_addr_t waddr_a;
    regfile_data_t wdata_a;
    logic          we_b;
    regfile_addr_t waddr_b;
    regfile_data_t wdata_b;
  } regfile_write_t;

  // Captured read pair waiting to be replayed on the core write ports.
  typedef struct packed {
    regfile_addr_t addr_a;
    regfile_data_t data_a;
    regfile_addr_t addr_b;
    regfile_data_t data_b;
  } rf_pair_t;

  typedef enum logic [RfRestoreStateBits-1:0] {
    RR_IDLE,
    RR_RUN,
    RR_LAST,
    RR_DONE
  } rf_restore_state_e;

endpackage

// File: rtl/recovery_rf_restorer.sv
// rtl/recovery_rf_restorer.sv - replays the backup regfile onto the core regfile, two registers per cycle
// Purpose: on start, reads backup register pairs (2i, 2i+1) and writes each pair
//   to the core regfile one cycle later, then pulses done_o.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   start_i          begin restore (sampled only when idle)
//   abort_i          synchronous abort, no done pulse, suppresses writes this cycle
//   stall_i          core write port unavailable, sequence holds
//   backup_raddr_o   read addresses to the backup regfile
//   backup_rdata_i   backup read data, combinational on backup_raddr_o
//   core_write_o     write ports A/B to the core regfile
//   busy_o, done_o   sequence in progress, single-cycle completion pulse
module recovery_rf_restorer
  import recovery_pkg::*;
#(
  parameter int NumRegs  = 32,
  parameter bit SkipZero = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic           abort_i,
  input  logic           stall_i,
  output regfile_raddr_t backup_raddr_o,
  input  regfile_rdata_t backup_rdata_i,
  output regfile_write_t core_write_o,
  output logic           busy_o,
  output logic           done_o
);

  localparam int NumPairs = (NumRegs + 1) / 2;
  localparam int PtrW     = $clog2(NumPairs + 1);

  typedef logic [PtrW-1:0] ptr_t;
  localparam ptr_t LastPtr = ptr_t'(NumPairs - 1);

  rf_restore_state_e state_q, state_d;
  ptr_t              ptr_q, ptr_d;
  logic              valid_q, valid_d;
  rf_pair_t          wr_q, wr_d;

  logic [PtrW:0]  base2;
  regfile_raddr_t rd_addr;
  logic           wr_go;
  logic           tail_b_ok;

  // The pointer only advances while the next pair exists, so in LAST it still
  // names the final pair and the read address stays put.
  always_comb begin
    base2          = {ptr_q, 1'b0};
    rd_addr.addr_a = regfile_addr_t'(base2);
    rd_addr.addr_b = {rd_addr.addr_a[RegfileAddr-1:1], 1'b1};
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    valid_d        = valid_q;
    wr_d           = wr_q;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    backup_raddr_o = '0;

    unique case (state_q)
      RR_IDLE: begin
        if (start_i) begin
          state_d = RR_RUN;
          ptr_d   = '0;
        end
      end
      RR_RUN: begin
        busy_o         = 1'b1;
        backup_raddr_o = rd_addr;
        if (!stall_i) begin
          valid_d = 1'b1;
          wr_d    = '{addr_a: rd_addr.addr_a, data_a: backup_rdata_i.data_a,
                      addr_b: rd_addr.addr_b, data_b: backup_rdata_i.data_b};
          if (ptr_q == LastPtr) begin
            state_d = RR_LAST;
          end else begin
            ptr_d = ptr_q + ptr_t'(1);
          end
        end
      end
      RR_LAST: begin
        busy_o         = 1'b1;
        backup_raddr_o = rd_addr;
        if (!stall_i) begin
          state_d = RR_DONE;
          valid_d = 1'b0;
        end
      end
      RR_DONE: begin
        done_o  = 1'b1;
        state_d = RR_IDLE;
      end
      default: state_d = RR_IDLE;
    endcase

    if (abort_i) begin
      state_d = RR_IDLE;
      ptr_d   = '0;
      valid_d = 1'b0;
    end
  end

  // Write enables are combinational on stall/abort so a held or aborted cycle
  // never reaches the core regfile even though the pair stays captured.
  always_comb begin
    wr_go     = valid_q & ~stall_i & ~abort_i;
    tail_b_ok = 32'(wr_q.addr_b) < NumRegs;

    core_write_o.we_a    = wr_go & ~(SkipZero & (wr_q.addr_a == '0));
    core_write_o.waddr_a = wr_q.addr_a;
    core_write_o.wdata_a = wr_q.data_a;
    core_write_o.we_b    = wr_go & tail_b_ok;
    core_write_o.waddr_b = wr_q.addr_b;
    core_write_o.wdata_b = wr_q.data_b;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RR_IDLE;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      wr_q    <= wr_d;
    end
  end

endmodule

// File: tb/tb_recovery_rf_restorer.sv
// tb/tb_recovery_rf_restorer.sv - model-checked bench for recovery_rf_restorer (32 and 31 register builds)
module tb_recovery_rf_restorer;
  import recovery_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic stall = 1'b0;

  always #5 clk = ~clk;

  logic [31:0]    bk [32];
  regfile_raddr_t raddr [2];
  regfile_rdata_t rdata [2];
  regfile_write_t wr [2];
  logic           busy [2];
  logic           done [2];

  assign rdata[0].data_a = bk[raddr[0].addr_a];
  assign rdata[0].data_b = bk[raddr[0].addr_b];
  assign rdata[1].data_a = bk[raddr[1].addr_a];
  assign rdata[1].data_b = bk[raddr[1].addr_b];

  recovery_rf_restorer #(.NumRegs(32), .SkipZero(1'b1)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .stall_i(stall),
    .backup_raddr_o(raddr[0]), .backup_rdata_i(rdata[0]), .core_write_o(wr[0]),
    .busy_o(busy[0]), .done_o(done[0]));

  recovery_rf_restorer #(.NumRegs(31), .SkipZero(1'b1)) u_dut31 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .stall_i(stall),
    .backup_raddr_o(raddr[1]), .backup_rdata_i(rdata[1]), .core_write_o(wr[1]),
    .busy_o(busy[1]), .done_o(done[1]));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: n counts non-stalled active cycles since start. Read pair is
  // min(n, P-1), write pair is n-1, and the sequence ends after n reaches P.
  int NR [2] = '{32, 31};
  bit m_active [2];
  int m_n [2];
  bit m_done [2];
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_active[k] <= 1'b0;
        m_n[k]      <= 0;
        m_done[k]   <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (abort) begin
          m_active[k] <= 1'b0;
          m_done[k]   <= 1'b0;
          m_n[k]      <= 0;
        end else if (m_done[k]) begin
          m_done[k] <= 1'b0;
        end else if (!m_active[k]) begin
          if (start) begin
            m_active[k] <= 1'b1;
            m_n[k]      <= 0;
          end
        end else if (!stall) begin
          if (m_n[k] == (NR[k] + 1) / 2) begin
            m_active[k] <= 1'b0;
            m_done[k]   <= 1'b1;
          end else begin
            m_n[k] <= m_n[k] + 1;
          end
        end
      end
    end
  end

  int tot_wcyc [2] = '{0, 0};
  int tot_wea [2] = '{0, 0};
  int tot_web [2] = '{0, 0};
  int tot_busy [2] = '{0, 0};
  int tot_done [2] = '{0, 0};
  int tot_a10 [2] = '{0, 0};
  int last_done_cyc [2] = '{0, 0};
  int a1_cyc [2] = '{0, 0};
  logic [31:0] a1_data [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int p, pair, wp;
      bit go, ewa, ewb;
      p    = (NR[k] + 1) / 2;
      pair = (m_n[k] < p) ? m_n[k] : p - 1;
      wp   = m_n[k] - 1;
      go   = m_active[k] && m_n[k] >= 1 && !stall && !abort;
      ewa  = go && (2 * wp != 0);
      ewb  = go && (2 * wp + 1 < NR[k]);
      check($sformatf("busy%0d", k), 128'(busy[k]), 128'(m_active[k]));
      check($sformatf("done%0d", k), 128'(done[k]), 128'(m_done[k]));
      check($sformatf("raddr_a%0d", k), 128'(raddr[k].addr_a), m_active[k] ? 128'((2 * pair) % 32) : 128'(0));
      check($sformatf("raddr_b%0d", k), 128'(raddr[k].addr_b), m_active[k] ? 128'((2 * pair + 1) % 32) : 128'(0));
      check($sformatf("we_a%0d", k), 128'(wr[k].we_a), 128'(ewa));
      check($sformatf("we_b%0d", k), 128'(wr[k].we_b), 128'(ewb));
      if (ewa) begin
        check($sformatf("waddr_a%0d", k), 128'(wr[k].waddr_a), 128'(2 * wp));
        check($sformatf("wdata_a%0d", k), 128'(wr[k].wdata_a), 128'(bk[2 * wp]));
      end
      if (ewb) begin
        check($sformatf("waddr_b%0d", k), 128'(wr[k].waddr_b), 128'(2 * wp + 1));
        check($sformatf("wdata_b%0d", k), 128'(wr[k].wdata_b), 128'(bk[2 * wp + 1]));
      end
      if (wr[k].we_a || wr[k].we_b) tot_wcyc[k]++;
      if (wr[k].we_a) tot_wea[k]++;
      if (wr[k].we_b) tot_web[k]++;
      if (busy[k]) tot_busy[k]++;
      if (done[k]) begin
        tot_done[k]++;
        last_done_cyc[k] = cyc;
      end
      if (wr[k].we_a && wr[k].waddr_a == 5'd10) tot_a10[k]++;
      if (wr[k].we_b && wr[k].waddr_b == 5'd1) begin
        a1_cyc[k]  = cyc;
        a1_data[k] = wr[k].wdata_b;
      end
    end
  end

  int s_wcyc [2], s_wea [2], s_web [2], s_busy [2], s_done [2], s_a10 [2];
  int t0 = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int k = 0; k < 2; k++) begin
      s_wcyc[k] = tot_wcyc[k];
      s_wea[k]  = tot_wea[k];
      s_web[k]  = tot_web[k];
      s_busy[k] = tot_busy[k];
      s_done[k] = tot_done[k];
      s_a10[k]  = tot_a10[k];
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_busy%0d", tag, k), 128'(busy[k]), 128'(0));
      check($sformatf("%s_done%0d", tag, k), 128'(done[k]), 128'(0));
      check($sformatf("%s_raddr%0d", tag, k), 128'(raddr[k]), 128'(0));
      check($sformatf("%s_write%0d", tag, k), 128'(wr[k]), 128'(0));
    end
  endtask

  // Cycle c of the run is the clock interval t0+c; start is sampled at c=0.
  task automatic run(input int ncyc, input int st_lo, input int st_hi,
                     input int abort_at, input int restart_at, input int reset_at);
    snap();
    t0 = cyc;
    for (int c = 0; c < ncyc; c++) begin
      start = (c == 0 || c == restart_at);
      stall = (c >= st_lo && c <= st_hi);
      abort = (c == abort_at);
      if (c == reset_at) begin
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check_zero("midreset");
      end
      if (c == reset_at + 2) rst_n = 1'b1;
      tick();
    end
    start = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) bk[r] = 32'hA000_0000 + r;
    tick();
    tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();
    tick();

    // Plain restore of both builds.
    run(24, -1, -1, -1, -1, -1);
    check("full_wcyc32", 128'(tot_wcyc[0] - s_wcyc[0]), 128'(16));
    check("full_wea32", 128'(tot_wea[0] - s_wea[0]), 128'(15));
    check("full_web32", 128'(tot_web[0] - s_web[0]), 128'(16));
    check("full_busy32", 128'(tot_busy[0] - s_busy[0]), 128'(17));
    check("full_ndone32", 128'(tot_done[0] - s_done[0]), 128'(1));
    check("full_donecyc32", 128'(last_done_cyc[0] - t0), 128'(18));
    check("full_a1cyc32", 128'(a1_cyc[0] - t0), 128'(2));
    check("full_a1data32", 128'(a1_data[0]), 128'(32'hA000_0001));
    check("full_wea31", 128'(tot_wea[1] - s_wea[1]), 128'(15));
    check("full_web31", 128'(tot_web[1] - s_web[1]), 128'(15));
    check("full_donecyc31", 128'(last_done_cyc[1] - t0), 128'(18));

    // Three stalled cycles while pair (10,11) is pending.
    run(28, 7, 9, -1, -1, -1);
    check("stall_wcyc32", 128'(tot_wcyc[0] - s_wcyc[0]), 128'(16));
    check("stall_a10_32", 128'(tot_a10[0] - s_a10[0]), 128'(1));
    check("stall_donecyc32", 128'(last_done_cyc[0] - t0), 128'(21));
    check("stall_donecyc31", 128'(last_done_cyc[1] - t0), 128'(21));

    // Abort while pair 5 is pending, then a clean restart.
    run(24, -1, -1, 7, -1, -1);
    check("abort_ndone32", 128'(tot_done[0] - s_done[0]), 128'(0));
    check("abort_ndone31", 128'(tot_done[1] - s_done[1]), 128'(0));
    check("abort_wcyc32", 128'(tot_wcyc[0] - s_wcyc[0]), 128'(5));
    run(24, -1, -1, -1, -1, -1);
    check("rerun_wcyc32", 128'(tot_wcyc[0] - s_wcyc[0]), 128'(16));
    check("rerun_donecyc32", 128'(last_done_cyc[0] - t0), 128'(18));

    // Reset in the middle of a sequence, then idle with no start.
    run(20, -1, -1, -1, -1, 7);
    check("reset_ndone32", 128'(tot_done[0] - s_done[0]), 128'(0));
    check("reset_wcyc32", 128'(tot_wcyc[0] - s_wcyc[0]), 128'(5));
    check_zero("postreset");

    // start re-pulsed while busy is ignored.
    run(24, -1, -1, -1, 5, -1);
    check("repulse_wcyc32", 128'(tot_wcyc[0] - s_wcyc[0]), 128'(16));
    check("repulse_ndone32", 128'(tot_done[0] - s_done[0]), 128'(1));

    // Randomised traffic on random backup contents.
    for (int r = 0; r < 32; r++) bk[r] = $urandom;
    snap();
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 63) == 0);
      tick();
    end
    start = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
    repeat (4) tick();
    check("rand_progress32", 128'(tot_wcyc[0] - s_wcyc[0] > 0), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
